// File: rtl/coffee_pkg.sv
// Shared types for the coffee panel: flavour/sugar codes, panel states, price lookup.
// Latency: none (types and pure functions only).
// Backpressure: not applicable.
package coffee_pkg;

  typedef enum logic [1:0] {
    FLAV_ESPRESSO   = 2'b00,
    FLAV_CAPPUCCINO = 2'b01,
    FLAV_LATTE      = 2'b10,
    FLAV_MOCHA      = 2'b11
  } flavour_t;

  typedef enum logic [1:0] {
    SUGAR_NONE = 2'b00,
    SUGAR_FULL = 2'b01,
    SUGAR_LESS = 2'b10
  } sugar_t;

  typedef enum logic [1:0] {
    ST_SELECT,
    ST_ISSUE,
    ST_BREWING,
    ST_REFUND
  } panel_state_t;

  // Price of the given flavour; prices are passed in so the top's parameters stay authoritative.
  function automatic logic [7:0] price_of(flavour_t f, int p_esp, int p_cap, int p_lat, int p_moc);
    logic [7:0] p;
    case (f)
      FLAV_ESPRESSO:   p = 8'(p_esp);
      FLAV_CAPPUCCINO: p = 8'(p_cap);
      FLAV_LATTE:      p = 8'(p_lat);
      default:         p = 8'(p_moc);
    endcase
    return p;
  endfunction

  // Flavour wraps mocha -> espresso.
  function automatic flavour_t next_flavour(flavour_t f);
    return flavour_t'(f + 2'd1);
  endfunction

  // Sugar cycles none -> full -> less -> none.
  function automatic sugar_t next_sugar(sugar_t s);
    sugar_t n;
    case (s)
      SUGAR_NONE: n = SUGAR_FULL;
      SUGAR_FULL: n = SUGAR_LESS;
      default:    n = SUGAR_NONE;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/coffee_order_panel_if.sv
// Order channel between the panel (master) and the brew controller (slave).
// Latency: wires only.
// Backpressure: order_valid is held until order_ready; brew_done is a level.
interface coffee_order_panel_if;
  import coffee_pkg::*;

  logic     order_valid;
  logic     order_ready;
  flavour_t flavour_select;
  sugar_t   sugar_select;
  logic     brew_done;

  modport master (
    output order_valid,
    output flavour_select,
    output sugar_select,
    input  order_ready,
    input  brew_done
  );

  modport slave (
    input  order_valid,
    input  flavour_select,
    input  sugar_select,
    output order_ready,
    output brew_done
  );

endinterface

// File: rtl/panel_debounce.sv
// Button conditioner: 2-FF synchronizer, stability filter, rising-edge press pulse.
// Latency: raw rise to press pulse is 2+DEBOUNCE_CYCLES cycles.
// Backpressure: none; a held button gives exactly one pulse.
module panel_debounce #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic press
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic          sync1;
  logic          sync2;
  logic          stable;
  logic [CW-1:0] cnt;

  // Two-flop synchronizer for the asynchronous button level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
    end
  end

  // Accept a new level after DEBOUNCE_CYCLES consecutive differing samples; pulse on accepted 0->1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stable <= 1'b0;
      cnt    <= '0;
      press  <= 1'b0;
    end else if (sync2 != stable) begin
      if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
        stable <= sync2;
        cnt    <= '0;
        press  <= sync2;
      end else begin
        cnt    <= cnt + CW'(1);
        press  <= 1'b0;
      end
    end else begin
      cnt   <= '0;
      press <= 1'b0;
    end
  end

endmodule

// File: rtl/coffee_order_panel.sv
// Coffee panel front end: button handling, coin credit, price check, one order per start, change refund.
// Latency: all outputs registered; coin reaches credit one cycle after its strobe.
// Backpressure: order_valid held until order_ready or cancel/timeout; coins rejected while brewing/refunding.
module coffee_order_panel
  import coffee_pkg::*;
#(
  parameter int PRICE_ESPRESSO   = 20,
  parameter int PRICE_CAPPUCCINO = 25,
  parameter int PRICE_LATTE      = 30,
  parameter int PRICE_MOCHA      = 35,
  parameter int DEBOUNCE_CYCLES  = 4,
  parameter int TIMEOUT_CYCLES   = 255
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        btn_flavour,
  input  logic                        btn_sugar,
  input  logic                        btn_start,
  input  logic                        btn_cancel,
  input  logic                        coin_valid,
  input  logic [7:0]                  coin_value,
  coffee_order_panel_if.master        brew,
  output logic [7:0]                  credit,
  output logic                        change_valid,
  output logic [7:0]                  change_value,
  output logic                        coin_reject,
  output logic [3:0]                  led_flavor,
  output logic [2:0]                  led_sugar,
  output logic                        busy,
  output logic                        error_led
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic press_flavour, press_sugar, press_start, press_cancel;

  panel_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_flavour (
    .clk(clk), .rst_n(rst_n), .raw(btn_flavour), .press(press_flavour));
  panel_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_sugar (
    .clk(clk), .rst_n(rst_n), .raw(btn_sugar), .press(press_sugar));
  panel_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_start (
    .clk(clk), .rst_n(rst_n), .raw(btn_start), .press(press_start));
  panel_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_cancel (
    .clk(clk), .rst_n(rst_n), .raw(btn_cancel), .press(press_cancel));

  panel_state_t   state_q, state_d;
  flavour_t       flav_q, flav_d;
  sugar_t         sugar_q, sugar_d;
  logic [7:0]     credit_q, credit_d;
  logic [TW-1:0]  tmo_q, tmo_d;
  logic           armed_q, armed_d;
  logic           err_d, reject_d;
  logic           order_valid_q;
  logic [7:0]     price, base, coin_amt;
  logic [8:0]     sum;

  // Next-state, credit arithmetic and pulse decisions for the panel FSM.
  always_comb begin
    state_d  = state_q;
    flav_d   = flav_q;
    sugar_d  = sugar_q;
    credit_d = credit_q;
    tmo_d    = '0;
    armed_d  = armed_q;
    err_d    = 1'b0;
    reject_d = 1'b0;
    price    = price_of(flav_q, PRICE_ESPRESSO, PRICE_CAPPUCCINO, PRICE_LATTE, PRICE_MOCHA);
    coin_amt = coin_valid ? coin_value : 8'd0;
    base     = credit_q;
    sum      = {1'b0, base} + {1'b0, coin_amt};

    case (state_q)
      ST_SELECT: begin
        // Coin always lands; overflow clamps and flags.
        credit_d = sum[8] ? 8'hFF : sum[7:0];
        err_d    = sum[8];
        if (press_cancel) begin
          if (credit_q != 8'd0) state_d = ST_REFUND;
        end else if (press_start) begin
          // Price check uses credit before this cycle's coin.
          if (credit_q >= price) state_d = ST_ISSUE;
          else                   err_d   = 1'b1;
        end else begin
          if (press_flavour) flav_d  = next_flavour(flav_q);
          if (press_sugar)   sugar_d = next_sugar(sugar_q);
        end
      end

      ST_ISSUE: begin
        // order_valid is high throughout ISSUE, so ready alone completes the handshake.
        if (brew.order_ready) base = credit_q - price;
        sum      = {1'b0, base} + {1'b0, coin_amt};
        credit_d = sum[8] ? 8'hFF : sum[7:0];
        err_d    = sum[8];
        if (brew.order_ready) begin
          state_d = ST_BREWING;
        end else if (press_cancel || (tmo_q == TW'(TIMEOUT_CYCLES - 1))) begin
          state_d = ST_REFUND;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end

      ST_BREWING: begin
        reject_d = coin_valid;
        // A done level left over from the last order must drop before it counts again.
        if (!brew.brew_done) begin
          armed_d = 1'b1;
        end else if (armed_q) begin
          armed_d = 1'b0;
          state_d = (credit_q != 8'd0) ? ST_REFUND : ST_SELECT;
        end
      end

      default: begin
        reject_d = coin_valid;
        credit_d = 8'd0;
        state_d  = ST_SELECT;
      end
    endcase
  end

  // State and registered outputs; change is loaded on entry to REFUND.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_SELECT;
      flav_q        <= FLAV_ESPRESSO;
      sugar_q       <= SUGAR_NONE;
      credit_q      <= 8'd0;
      tmo_q         <= '0;
      armed_q       <= 1'b1;
      order_valid_q <= 1'b0;
      busy          <= 1'b0;
      change_valid  <= 1'b0;
      change_value  <= 8'd0;
      coin_reject   <= 1'b0;
      error_led     <= 1'b0;
      led_flavor    <= 4'b0001;
      led_sugar     <= 3'b001;
    end else begin
      state_q       <= state_d;
      flav_q        <= flav_d;
      sugar_q       <= sugar_d;
      credit_q      <= credit_d;
      tmo_q         <= tmo_d;
      armed_q       <= armed_d;
      order_valid_q <= (state_d == ST_ISSUE);
      busy          <= (state_d == ST_ISSUE) || (state_d == ST_BREWING);
      change_valid  <= (state_d == ST_REFUND);
      change_value  <= (state_d == ST_REFUND) ? credit_d : 8'd0;
      coin_reject   <= reject_d;
      error_led     <= err_d;
      led_flavor    <= 4'b0001 << flav_d;
      led_sugar     <= 3'b001 << sugar_d;
    end
  end

  assign credit              = credit_q;
  assign brew.order_valid    = order_valid_q;
  assign brew.flavour_select = flav_q;
  assign brew.sugar_select   = sugar_q;

endmodule

// File: tb/tb_coffee_order_panel.sv
// Directed bench for coffee_order_panel: vector table for panel/coin behaviour, hand sequences for orders.
// Latency: checks sample 1 ns after each rising edge.
// Backpressure: order_ready/brew_done driven by the bench as the brew controller.
`timescale 1ns/1ps
module tb_coffee_order_panel;
  import coffee_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       btn_flavour = 1'b0, btn_sugar = 1'b0, btn_start = 1'b0, btn_cancel = 1'b0;
  logic       coin_valid = 1'b0;
  logic [7:0] coin_value = 8'd0;
  logic [7:0] credit, change_value;
  logic       change_valid, coin_reject, busy, error_led;
  logic [3:0] led_flavor;
  logic [2:0] led_sugar;

  always #5 clk = ~clk;

  coffee_order_panel_if brew_if();

  coffee_order_panel dut (
    .clk(clk), .rst_n(rst_n),
    .btn_flavour(btn_flavour), .btn_sugar(btn_sugar),
    .btn_start(btn_start), .btn_cancel(btn_cancel),
    .coin_valid(coin_valid), .coin_value(coin_value),
    .brew(brew_if),
    .credit(credit), .change_valid(change_valid), .change_value(change_value),
    .coin_reject(coin_reject), .led_flavor(led_flavor), .led_sugar(led_sugar),
    .busy(busy), .error_led(error_led)
  );

  int checks = 0;
  int failures = 0;
  int err_cnt, chg_cnt, rej_cnt, ov_cnt;
  logic [7:0] chg_val;

  typedef enum int {OP_FLAV, OP_SUGAR, OP_START, OP_CANCEL, OP_COIN} op_t;
  typedef struct {
    op_t op;
    int  val;
    int  exp_flav;
    int  exp_sugar;
    int  exp_credit;
    int  exp_err;
    int  exp_chg;
    int  exp_chg_val;
  } vec_t;
  vec_t tbl[17];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic clear_mon();
    err_cnt = 0; chg_cnt = 0; rej_cnt = 0; ov_cnt = 0; chg_val = 8'd0;
  endtask

  task automatic run_cycles(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
      if (error_led) err_cnt++;
      if (change_valid) begin chg_cnt++; chg_val = change_value; end
      if (coin_reject) rej_cnt++;
      if (brew_if.order_valid) ov_cnt++;
    end
  endtask

  task automatic set_btn(input op_t op, input logic v);
    case (op)
      OP_FLAV:   btn_flavour = v;
      OP_SUGAR:  btn_sugar   = v;
      OP_START:  btn_start   = v;
      OP_CANCEL: btn_cancel  = v;
      default:   ;
    endcase
  endtask

  task automatic press(input op_t op);
    set_btn(op, 1'b1);
    run_cycles(10);
    set_btn(op, 1'b0);
    run_cycles(10);
  endtask

  task automatic coin(input logic [7:0] v);
    coin_valid = 1'b1;
    coin_value = v;
    run_cycles(1);
    coin_valid = 1'b0;
    coin_value = 8'd0;
    run_cycles(2);
  endtask

  initial begin
    logic [3:0] ef;
    logic [2:0] es;
    logic [1:0] f2;
    logic [1:0] s2;

    //            op         val  flav sug credit err chg chgval
    tbl[0]  = '{OP_FLAV,   0,   1, 0,   0, 0, 0,   0};
    tbl[1]  = '{OP_FLAV,   0,   2, 0,   0, 0, 0,   0};
    tbl[2]  = '{OP_FLAV,   0,   3, 0,   0, 0, 0,   0};
    tbl[3]  = '{OP_SUGAR,  0,   3, 1,   0, 0, 0,   0};
    tbl[4]  = '{OP_FLAV,   0,   0, 1,   0, 0, 0,   0};
    tbl[5]  = '{OP_SUGAR,  0,   0, 2,   0, 0, 0,   0};
    tbl[6]  = '{OP_SUGAR,  0,   0, 0,   0, 0, 0,   0};
    tbl[7]  = '{OP_COIN,   15,  0, 0,  15, 0, 0,   0};
    tbl[8]  = '{OP_START,  0,   0, 0,  15, 1, 0,   0};
    tbl[9]  = '{OP_COIN,   200, 0, 0, 215, 0, 0,   0};
    tbl[10] = '{OP_COIN,   100, 0, 0, 255, 1, 0,   0};
    tbl[11] = '{OP_COIN,   1,   0, 0, 255, 1, 0,   0};
    tbl[12] = '{OP_CANCEL, 0,   0, 0,   0, 0, 1, 255};
    tbl[13] = '{OP_CANCEL, 0,   0, 0,   0, 0, 0,   0};
    tbl[14] = '{OP_COIN,   255, 0, 0, 255, 0, 0,   0};
    tbl[15] = '{OP_COIN,   0,   0, 0, 255, 0, 0,   0};
    tbl[16] = '{OP_CANCEL, 0,   0, 0,   0, 0, 1, 255};

    brew_if.order_ready = 1'b0;
    brew_if.brew_done   = 1'b0;

    // Reset values while reset is held.
    repeat (2) @(posedge clk);
    #1;
    chk("rst_credit", credit, 0);
    chk("rst_flavour", brew_if.flavour_select, 0);
    chk("rst_sugar", brew_if.sugar_select, 0);
    chk("rst_led_flavor", led_flavor, 4'b0001);
    chk("rst_led_sugar", led_sugar, 3'b001);
    chk("rst_order_valid", brew_if.order_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_change_valid", change_valid, 0);
    chk("rst_error", error_led, 0);
    rst_n = 1'b1;
    run_cycles(3);

    // Table-driven panel and coin behaviour in SELECT.
    for (int i = 0; i < 17; i++) begin
      clear_mon();
      if (tbl[i].op == OP_COIN) coin(8'(tbl[i].val));
      else press(tbl[i].op);
      f2 = 2'(tbl[i].exp_flav);
      s2 = 2'(tbl[i].exp_sugar);
      ef = 4'b0001 << f2;
      es = 3'b001 << s2;
      chk($sformatf("v%0d_flavour", i), brew_if.flavour_select, f2);
      chk($sformatf("v%0d_sugar", i), brew_if.sugar_select, s2);
      chk($sformatf("v%0d_led_flavor", i), led_flavor, ef);
      chk($sformatf("v%0d_led_sugar", i), led_sugar, es);
      chk($sformatf("v%0d_credit", i), credit, tbl[i].exp_credit);
      chk($sformatf("v%0d_err_pulses", i), err_cnt, tbl[i].exp_err);
      chk($sformatf("v%0d_change_cnt", i), chg_cnt, tbl[i].exp_chg);
      if (tbl[i].exp_chg > 0) chk($sformatf("v%0d_change_val", i), chg_val, tbl[i].exp_chg_val);
      chk($sformatf("v%0d_busy", i), busy, 0);
    end

    // Espresso with exact credit: no change afterwards.
    clear_mon();
    coin(8'd10);
    coin(8'd10);
    chk("esp_credit_in", credit, 20);
    brew_if.order_ready = 1'b1;
    clear_mon();
    press(OP_START);
    chk("esp_ov_cycles", ov_cnt, 1);
    chk("esp_credit_after", credit, 0);
    chk("esp_busy", busy, 1);
    chk("esp_err", err_cnt, 0);
    clear_mon();
    brew_if.brew_done = 1'b1;
    run_cycles(3);
    brew_if.brew_done = 1'b0;
    run_cycles(2);
    chk("esp_done_busy", busy, 0);
    chk("esp_no_change", chg_cnt, 0);

    // Latte with 40 credit: 10 change; coin while brewing is rejected.
    press(OP_FLAV);
    press(OP_FLAV);
    chk("lat_flavour", brew_if.flavour_select, 2);
    coin(8'd20);
    coin(8'd20);
    clear_mon();
    press(OP_START);
    chk("lat_ov_cycles", ov_cnt, 1);
    chk("lat_credit_after", credit, 10);
    chk("lat_busy", busy, 1);
    clear_mon();
    coin(8'd5);
    chk("brew_coin_reject", rej_cnt, 1);
    chk("brew_coin_credit", credit, 10);
    clear_mon();
    brew_if.brew_done = 1'b1;
    run_cycles(3);
    brew_if.brew_done = 1'b0;
    run_cycles(2);
    chk("lat_change_cnt", chg_cnt, 1);
    chk("lat_change_val", chg_val, 10);
    chk("lat_credit_end", credit, 0);
    chk("lat_busy_end", busy, 0);

    // Timeout: ISSUE lasts exactly TIMEOUT_CYCLES then refunds all credit.
    brew_if.order_ready = 1'b0;
    coin(8'd40);
    clear_mon();
    press(OP_START);
    run_cycles(300);
    chk("tmo_ov_cycles", ov_cnt, 255);
    chk("tmo_change_cnt", chg_cnt, 1);
    chk("tmo_change_val", chg_val, 40);
    chk("tmo_credit", credit, 0);
    chk("tmo_order_valid", brew_if.order_valid, 0);
    chk("tmo_busy", busy, 0);

    // Cancel press and ready in the same cycle: handshake wins.
    coin(8'd35);
    press(OP_START);
    chk("cx_in_issue", brew_if.order_valid, 1);
    clear_mon();
    btn_cancel = 1'b1;
    run_cycles(6);
    brew_if.order_ready = 1'b1;
    run_cycles(1);
    brew_if.order_ready = 1'b0;
    run_cycles(3);
    btn_cancel = 1'b0;
    run_cycles(10);
    chk("cx_busy", busy, 1);
    chk("cx_credit", credit, 5);
    chk("cx_no_change", chg_cnt, 0);
    chk("cx_order_valid", brew_if.order_valid, 0);
    clear_mon();
    brew_if.brew_done = 1'b1;
    run_cycles(5);
    chk("cx_change_val", chg_val, 5);
    chk("cx_change_cnt", chg_cnt, 1);

    // brew_done still high from last order must not end the next brew; then reset mid-brew.
    coin(8'd30);
    brew_if.order_ready = 1'b1;
    clear_mon();
    press(OP_START);
    brew_if.order_ready = 1'b0;
    chk("rt_busy", busy, 1);
    chk("rt_credit", credit, 0);
    run_cycles(20);
    chk("rt_still_busy", busy, 1);
    chk("rt_no_change", chg_cnt, 0);
    clear_mon();
    coin(8'd7);
    chk("rt_coin_reject", rej_cnt, 1);
    chk("rt_coin_credit", credit, 0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_credit", credit, 0);
    chk("mid_rst_flavour", brew_if.flavour_select, 0);
    chk("mid_rst_led_flavor", led_flavor, 4'b0001);
    chk("mid_rst_change_valid", change_valid, 0);
    chk("mid_rst_order_valid", brew_if.order_valid, 0);
    brew_if.brew_done = 1'b0;
    run_cycles(2);
    rst_n = 1'b1;
    run_cycles(2);
    clear_mon();
    coin(8'd25);
    chk("post_rst_credit", credit, 25);
    chk("post_rst_no_change", chg_cnt, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/coffee_order_panel.md
Name: coffee_order_panel

Overview:
- Customer-facing front end of the coffee machine. Debounces the panel buttons, cycles the flavour and sugar selections, accumulates coin credit and checks the price.
- Issues one order to the brew controller over a valid/ready handshake. Waits for that controller's done level, then refunds leftover credit as change.
- Produces the flavour_select/sugar_select codes the brew controller consumes: flavour 00 espresso, 01 cappuccino, 10 latte, 11 mocha; sugar 00 none, 01 full, 10 less.

Parameters:
- PRICE_ESPRESSO, 20, credit units for flavour 00
- PRICE_CAPPUCCINO, 25, credit units for flavour 01
- PRICE_LATTE, 30, credit units for flavour 10
- PRICE_MOCHA, 35, credit units for flavour 11
- DEBOUNCE_CYCLES, 4, consecutive stable synchronized samples required before a button level is accepted
- TIMEOUT_CYCLES, 255, max cycles in ISSUE without order_ready before auto-refund

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- btn_flavour, btn_sugar, btn_start, btn_cancel  in  1 each  raw asynchronous buttons, active-high
- coin_valid  in  1  one-cycle coin strobe (synchronous)
- coin_value  in  8  coin value, sampled when coin_valid=1
- order_ready  in  1  brew controller can accept an order
- brew_done  in  1  brew controller done level
- order_valid  out  1  order offered
- flavour_select  out  2  selected flavour
- sugar_select  out  2  selected sugar
- credit  out  8  current credit
- change_valid  out  1  one-cycle change strobe
- change_value  out  8  change amount, valid with change_valid
- coin_reject  out  1  one-cycle pulse: coin not accepted
- led_flavor  out  4  one-hot flavour LED
- led_sugar  out  3  one-hot sugar LED: bit0 none, bit1 full, bit2 less
- busy  out  1  high in ISSUE and BREWING
- error_led  out  1  one-cycle pulse on a rejected start or a credit saturation

Behaviour:
- All outputs are registered.
- Reset (async, rst_n=0): state SELECT, credit 0, flavour_select 00, sugar_select 00, led_flavor 0001, led_sugar 001, all strobes/valid/busy/error 0, debouncers cleared. Reset mid-order discards credit with no change strobe.
- Buttons: 2-FF synchronizer. A level is accepted after DEBOUNCE_CYCLES equal samples. A 0->1 transition of the accepted level gives a one-cycle press pulse. Press-to-pulse latency is 2+DEBOUNCE_CYCLES cycles; a held button yields one pulse.
- Coins in SELECT/ISSUE: credit <= min(credit+coin_value, 255). If the sum exceeds 255, credit saturates at 255 and error_led pulses.
- Coins in BREWING/REFUND: credit unchanged, coin_reject pulses the next cycle.
- FSM states: SELECT, ISSUE, BREWING, REFUND.
- SELECT, flavour press: flavour cycles 00->01->10->11->00.
- SELECT, sugar press: sugar cycles 00->01->10->00.
- SELECT, start press: price is looked up from the current flavour. If credit (before this cycle's coin) >= price, go to ISSUE; otherwise error_led pulses and the state stays SELECT. A same-cycle coin is still added.
- SELECT, cancel press: go to REFUND if credit>0; otherwise ignore.
- Same-cycle presses: cancel beats start, start beats flavour/sugar.
- ISSUE: order_valid=1 with selections frozen; flavour/sugar presses are ignored. On order_valid && order_ready: credit <= credit-price (plus any same-cycle coin), order_valid drops next cycle, go to BREWING.
- ISSUE, cancel or timeout: cancel press, or TIMEOUT_CYCLES elapsed without the handshake -> REFUND, order_valid drops. If cancel and ready arrive in the same cycle, the handshake wins.
- BREWING: busy=1; buttons are ignored. When brew_done=1, go to REFUND if credit>0, else SELECT. brew_done held high afterwards is not re-triggered until it has been seen low in BREWING.
- REFUND: change_valid=1 and change_value=credit for exactly one cycle; credit <= 0; go to SELECT. The selections persist.
- LEDs always mirror the current selections.

Decomposition:
- Shared package coffee_pkg: flavour codes, sugar codes (SUGAR_NONE/FULL/LESS), panel state enum, price lookup function.
- One sub-module, panel_debounce: synchronizer + stability counter + rising-edge pulse. Four instances.

Test Plan:
- Flavour press x3, sugar press x1 (each held 10 cycles) -> led_flavor 1000, flavour_select 11, led_sugar 010, exactly one pulse per press.
- Coins 10+10, start on espresso, order_ready=1 -> order_valid for 1 cycle, credit 20->0, busy=1. brew_done -> SELECT with no change strobe.
- Coins 20+20, latte, start, handshake, brew_done -> change_valid with change_value 10, credit 0.
- Credit 15, start on espresso -> error_led single pulse, state SELECT, credit 15. Coins 200+100 -> credit 255 with error pulse.
- ISSUE with order_ready=0 for 255 cycles -> REFUND with change_value = full credit, order_valid 0.
- Cancel and order_ready in the same cycle -> handshake wins. rst_n low during BREWING -> all outputs at reset values immediately; coin during BREWING -> coin_reject pulse, credit unchanged.
